sg_config_arbiter: RTL
======================

Name: sg_config_arbiter

Overview:
Sequences configuration writes into the signal generator's write port (write_strobe, 3-bit address, 5-bit data). It arbitrates between two requesters:
- the external host pins, which have fixed priority;
- an internal step sequencer that replays a host-loaded program of {address, data} entries on each tempo tick.

The block runs on the fast system clock. It stretches every strobe so that the slower, scaled generator clock samples it reliably.

Parameters:
DEPTH, 8, number of program entries (power of two, ≥2)
STROBE_HOLD, 128, cycles sg_write_strobe stays high per write (must be ≥ one scaled-clock period)
GAP, 128, cycles strobe stays low after each write before the next grant

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
host_strobe  in  1  host write request pin, asynchronous; rising edge = one request
host_address  in  3  host register address; stable ≥4 cycles after host_strobe rise
host_data  in  5  host register data; same stability rule as host_address
host_prog  in  1  sampled with the request: 1 = store into program memory, 0 = direct generator write
seq_enable  in  1  level; allows step_tick to issue program writes
seq_clear  in  1  one-cycle pulse; empties the program
step_tick  in  1  one-cycle tempo pulse
sg_write_strobe  out  1  strobe to the generator
sg_address  out  3  address to the generator
sg_data  out  5  data to the generator
busy  out  1  FSM not in IDLE, or any request pending
seq_index  out  clog2(DEPTH)  current read pointer
prog_count  out  clog2(DEPTH)+1  number of valid program entries
host_overrun  out  1  sticky; a direct host request was overwritten before it was granted

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, wr_ptr/rd_ptr/prog_count 0, pending flags cleared. A strobe in progress is aborted. Memory contents are don't-care.
- Host input path:
  - host_strobe passes a 2-FF synchroniser, then a rising-edge detect.
  - On the edge cycle, host_address, host_data and host_prog are captured. Pin rise to capture = 3 clk cycles.
- Host request with host_prog=1:
  - mem[wr_ptr] <= {addr, data}; wr_ptr increments and wraps at DEPTH.
  - prog_count increments, saturating at DEPTH.
  - No generator write is issued.
- Host request with host_prog=0:
  - Sets host_pend with the captured value.
  - If host_pend is already set, the new value overwrites it and host_overrun is set. host_overrun clears only on rst.
- Sequencer request:
  - On step_tick with seq_enable=1, prog_count>0 and seq_pend=0: seq_pend <= mem[rd_ptr]; rd_ptr <= (rd_ptr+1 == prog_count) ? 0 : rd_ptr+1.
  - A tick that arrives while seq_pend=1 is dropped and rd_ptr is unchanged.
  - A tick with seq_enable=0 or prog_count=0 is ignored.
- FSM states IDLE, STROBE, GAP:
  - IDLE: host_pend has priority over seq_pend. The granted value loads sg_address/sg_data and its pending flag clears. The FSM enters STROBE in the next cycle, with sg_write_strobe=1 from that cycle.
  - STROBE: strobe held high for exactly STROBE_HOLD cycles, then → GAP.
  - GAP: strobe low for exactly GAP cycles, then → IDLE.
  - sg_address/sg_data stay stable through STROBE and GAP, and hold their last value in IDLE.
- Pending requests arriving during STROBE/GAP wait; they are never lost except through the host overwrite rule. Continuous host traffic may starve the sequencer; this is accepted.
- Simultaneous events:
  - A program write and a step_tick in the same cycle: the step reads the pre-write mem/prog_count.
  - A seq_clear and a step_tick in the same cycle: clear wins.
  - A seq_clear and a host program write in the same cycle: clear first, then the write lands at index 0, giving prog_count=1.
- seq_clear: wr_ptr, rd_ptr and prog_count go to 0 and seq_pend is dropped. A write already in STROBE/GAP completes.
- seq_enable falling: any queued seq_pend still issues; rd_ptr is retained.

Decomposition:
- Package sg_cfg_pkg holds:
  - ADDR_W=3, DATA_W=5;
  - the sg_entry_t struct {addr, data};
  - the arb_state_t enum {IDLE, STROBE, GAP}.
- One sub-module, sg_strobe_sync: 2-FF synchroniser plus rising-edge pulse, async active-high rst.

Test Plan:
- Host direct write addr=3, data=0x15, host_prog=0 → strobe rises 5 cycles after the pin rise and stays high 128 cycles; sg_address=3, sg_data=0x15 stable for 256 cycles.
- Load 3 program entries (1,0x04),(2,0x08),(3,0x10), then 4 step_ticks spaced 300 cycles apart with seq_enable=1 → writes issue in order 1,2,3,1; seq_index sequence is 1,2,0,1; prog_count=3.
- Host direct request and step_tick in the same cycle while IDLE → the host write is issued first; the sequencer write starts exactly 256 cycles after the host strobe rises.
- Two host direct requests 20 cycles apart during an active strobe → only the second value is written and host_overrun=1.
- 9 program writes with DEPTH=8 → prog_count saturates at 8 and entry 0 holds the 9th value; then seq_clear → prog_count=0 and following ticks produce no strobe.
- Assert rst mid-STROBE → sg_write_strobe goes 0 asynchronously, all counters are 0, and there is no strobe after release until a new request.

Source files
------------

// File: rtl/sg_cfg_pkg.sv
// sg_cfg_pkg: shared widths, program entry type and arbiter states for the config arbiter
package sg_cfg_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 5;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sg_entry_t;
  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_GAP} arb_state_t;
endpackage

// File: rtl/sg_strobe_sync.sv
// sg_strobe_sync: 2-FF synchroniser for an asynchronous pin plus a one-cycle rising-edge pulse
module sg_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic [2:0] sync_d, sync_q;
  always_comb sync_d = {sync_q[1:0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign pulse = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/sg_config_arbiter.sv
// sg_config_arbiter: arbitrates host pin writes and a step-sequencer program onto the generator
// write port, stretching each strobe so the slower scaled generator clock samples it.
module sg_config_arbiter
  import sg_cfg_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int STROBE_HOLD = 128,
  parameter int GAP         = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_strobe,
  input  logic [ADDR_W-1:0]        host_address,
  input  logic [DATA_W-1:0]        host_data,
  input  logic                     host_prog,
  input  logic                     seq_enable,
  input  logic                     seq_clear,
  input  logic                     step_tick,
  output logic                     sg_write_strobe,
  output logic [ADDR_W-1:0]        sg_address,
  output logic [DATA_W-1:0]        sg_data,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] seq_index,
  output logic [$clog2(DEPTH):0]   prog_count,
  output logic                     host_overrun
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2((STROBE_HOLD > GAP ? STROBE_HOLD : GAP) + 1);
  logic host_pulse, prog_we, host_req, step_ok, grant_host, grant_seq;
  logic cap_vld_d, cap_vld_q, cap_prog_d, cap_prog_q;
  logic host_pend_d, host_pend_q, seq_pend_d, seq_pend_q, ovr_d, ovr_q;
  sg_entry_t cap_d, cap_q, host_d, host_q, seq_d, seq_q, out_d, out_q;
  logic [PW-1:0] wr_d, wr_q, rd_d, rd_q, widx;
  logic [PW:0] cnt_d, cnt_q;
  logic [CW-1:0] tmr_d, tmr_q;
  arb_state_t st_d, st_q;
  sg_entry_t mem_q [DEPTH];
  sg_strobe_sync u_sync (.clk(clk), .rst(rst), .d(host_strobe), .pulse(host_pulse));
  always_comb begin
    cap_d       = host_pulse ? {host_address, host_data} : cap_q;
    cap_prog_d  = host_pulse ? host_prog : cap_prog_q;
    cap_vld_d   = host_pulse;
    prog_we     = cap_vld_q & cap_prog_q;
    host_req    = cap_vld_q & ~cap_prog_q;
    // clear beats a same-cycle tick; the tick sees pre-write memory and count
    step_ok     = step_tick & seq_enable & (cnt_q != '0) & ~seq_pend_q & ~seq_clear;
    grant_host  = (st_q == ST_IDLE) & host_pend_q;
    grant_seq   = (st_q == ST_IDLE) & ~host_pend_q & seq_pend_q & ~seq_clear;
    widx        = seq_clear ? '0 : wr_q;
    wr_d        = widx + PW'(prog_we);
    cnt_d       = seq_clear ? (PW+1)'(prog_we)
                            : cnt_q + (PW+1)'(prog_we & (cnt_q != (PW+1)'(DEPTH)));
    rd_d        = seq_clear ? '0
                : step_ok   ? (({1'b0, rd_q} + 1'b1 == cnt_q) ? '0 : rd_q + 1'b1) : rd_q;
    host_d      = host_req ? cap_q : host_q;
    host_pend_d = host_req | (host_pend_q & ~grant_host);
    ovr_d       = ovr_q | (host_req & host_pend_q & ~grant_host);
    seq_d       = step_ok ? mem_q[rd_q] : seq_q;
    seq_pend_d  = ~seq_clear & (step_ok | (seq_pend_q & ~grant_seq));
    out_d       = grant_host ? host_q : grant_seq ? seq_q : out_q;
    st_d        = st_q;
    tmr_d       = tmr_q + 1'b1;
    if (st_q == ST_IDLE) begin
      tmr_d = '0;
      st_d  = (grant_host | grant_seq) ? ST_STROBE : ST_IDLE;
    end else if (st_q == ST_STROBE && tmr_q == CW'(STROBE_HOLD - 1)) begin
      tmr_d = '0;
      st_d  = ST_GAP;
    end else if (st_q == ST_GAP && tmr_q == CW'(GAP - 2)) begin
      st_d  = ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cap_q       <= '0;
      cap_prog_q  <= 1'b0;
      cap_vld_q   <= 1'b0;
      host_q      <= '0;
      host_pend_q <= 1'b0;
      ovr_q       <= 1'b0;
      seq_q       <= '0;
      seq_pend_q  <= 1'b0;
      out_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      st_q        <= ST_IDLE;
    end else begin
      cap_q       <= cap_d;
      cap_prog_q  <= cap_prog_d;
      cap_vld_q   <= cap_vld_d;
      host_q      <= host_d;
      host_pend_q <= host_pend_d;
      ovr_q       <= ovr_d;
      seq_q       <= seq_d;
      seq_pend_q  <= seq_pend_d;
      out_q       <= out_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      st_q        <= st_d;
    end
  always_ff @(posedge clk)
    if (prog_we) mem_q[widx] <= cap_q;
  assign sg_write_strobe = (st_q == ST_STROBE);
  assign sg_address      = out_q.addr;
  assign sg_data         = out_q.data;
  assign busy            = (st_q != ST_IDLE) | host_pend_q | seq_pend_q | cap_vld_q;
  assign seq_index       = rd_q;
  assign prog_count      = cnt_q;
  assign host_overrun    = ovr_q;
endmodule
